// File: rtl/capture_clken_gen.sv
// capture_clken_gen: lock-qualified, runtime-programmable clock-enable generator.
// NUM_OUT channels, each with its own divide ratio and phase. A new setting takes
// effect only at that channel's period boundary, so pulse trains never glitch.
// Optional feature macro: CAPTURE_CLKEN_RESYNC_EN (when defined, `resync` realigns
// all channel counters and applies pending configs; when undefined, `resync` is ignored).
module capture_clken_gen #(
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_STABLE = 1024,
  localparam int unsigned CHAN_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CHAN_W-1:0]  cfg_chan,
  input  logic               cfg_en,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  input  logic               resync,
  output logic [NUM_OUT-1:0] clken,
  output logic               running,
  output logic               lock_lost
);

  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

  typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_lock_meta, r_lock_sync;
  logic [STAB_W-1:0]    r_stable;
  logic                 r_lock_lost;
  logic [NUM_OUT-1:0]   r_en_a, r_en_s, r_pending, r_clken;
  logic [DIV_W-1:0]     r_div_a [NUM_OUT];
  logic [DIV_W-1:0]     r_ph_a  [NUM_OUT];
  logic [DIV_W-1:0]     r_div_s [NUM_OUT];
  logic [DIV_W-1:0]     r_ph_s  [NUM_OUT];
  logic [DIV_W-1:0]     r_cnt   [NUM_OUT];

  logic                 w_run, w_resync, w_pend_sel, w_wr;
  logic [DIV_W-1:0]     w_div_n, w_ph_n;
  logic [NUM_OUT-1:0]   w_wr_sel, w_wrap, w_apply;

  // Double-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // FSM state register
  always_ff @(posedge refclk) begin
    if (rst) r_state <= WAIT_LOCK;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: qualify lock for LOCK_STABLE cycles, fall back on any drop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_LOCK: if (r_lock_sync && (r_stable == STAB_W'(LOCK_STABLE - 1))) w_state_nxt = RUN;
      RUN:       if (!r_lock_sync) w_state_nxt = WAIT_LOCK;
      default:   w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Consecutive synchronised-lock counter, only meaningful while waiting
  always_ff @(posedge refclk) begin
    if (rst || (r_state == RUN) || !r_lock_sync) r_stable <= '0;
    else                                         r_stable <= r_stable + STAB_W'(1);
  end

  // Sticky lock-loss flag, cleared only by reset
  always_ff @(posedge refclk) begin
    if (rst)                          r_lock_lost <= 1'b0;
    else if (w_run && !r_lock_sync)   r_lock_lost <= 1'b1;
  end

  assign w_run = (r_state == RUN);

`ifdef CAPTURE_CLKEN_RESYNC_EN
  assign w_resync = w_run && resync;
`else
  logic w_unused_resync;
  assign w_unused_resync = resync;
  assign w_resync        = 1'b0;
`endif

  // Config decode: normalise divide, clamp phase, ready from the selected pending flag
  always_comb begin
    w_div_n    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    w_ph_n     = (cfg_phase >= w_div_n) ? (w_div_n - DIV_W'(1)) : cfg_phase;
    w_pend_sel = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (cfg_chan == CHAN_W'(i)) w_pend_sel = r_pending[i];
    end
    cfg_ready = !w_pend_sel;
    w_wr      = cfg_valid && cfg_ready;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_wr_sel[i] = w_wr && (cfg_chan == CHAN_W'(i));
    end
  end

  // Per-channel period boundary and apply decision
  always_comb begin
    w_wrap  = '0;
    w_apply = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_wrap[i]  = (r_cnt[i] == (r_div_a[i] - DIV_W'(1)));
      w_apply[i] = r_pending[i] && (!w_run || !r_en_a[i] || w_wrap[i] || w_resync);
    end
  end

  // Shadow/active configuration registers
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_en_a    <= '0;
      r_en_s    <= '0;
      r_pending <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        r_div_a[i] <= DIV_W'(1);
        r_ph_a[i]  <= '0;
        r_div_s[i] <= DIV_W'(1);
        r_ph_s[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_wr_sel[i]) begin
          r_en_s[i]    <= cfg_en;
          r_div_s[i]   <= w_div_n;
          r_ph_s[i]    <= w_ph_n;
          r_pending[i] <= 1'b1;
        end else if (w_apply[i]) begin
          r_en_a[i]    <= r_en_s[i];
          r_div_a[i]   <= r_div_s[i];
          r_ph_a[i]    <= r_ph_s[i];
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Period counters: held at zero until RUN, restart on apply, wrap, or resync
  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      if (rst || !w_run || w_apply[i] || w_resync || w_wrap[i]) r_cnt[i] <= '0;
      else                                                      r_cnt[i] <= r_cnt[i] + DIV_W'(1);
    end
  end

  // Registered enables; suppressed as soon as the synchronised lock drops
  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      if (rst) r_clken[i] <= 1'b0;
      else     r_clken[i] <= w_run && r_lock_sync && r_en_a[i] && (r_cnt[i] == r_ph_a[i]);
    end
  end

  assign clken     = r_clken;
  assign running   = w_run;
  assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_capture_clken_gen.sv
// Directed self-checking bench for capture_clken_gen (NUM_OUT=3, LOCK_STABLE=16).
// Resync expectations follow CAPTURE_CLKEN_RESYNC_EN as seen by this compile.
module tb_capture_clken_gen;

  localparam int unsigned NUM_OUT     = 3;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned LOCK_STABLE = 16;
  localparam int unsigned CHAN_W      = 2;

  logic               refclk = 1'b0;
  logic               rst, pll_locked, cfg_valid, cfg_ready, cfg_en, resync;
  logic               running, lock_lost;
  logic [CHAN_W-1:0]  cfg_chan;
  logic [DIV_W-1:0]   cfg_div, cfg_phase;
  logic [NUM_OUT-1:0] clken;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 refclk = ~refclk;

  capture_clken_gen #(
    .NUM_OUT(NUM_OUT), .DIV_W(DIV_W), .LOCK_STABLE(LOCK_STABLE)
  ) u_dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .resync(resync), .clken(clken), .running(running), .lock_lost(lock_lost)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic en, input int dv, input int ph);
    cfg_chan  = CHAN_W'(ch);
    cfg_en    = en;
    cfg_div   = DIV_W'(dv);
    cfg_phase = DIV_W'(ph);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input int ch, input string tag);
    int n;
    n = 0;
    cfg_chan = CHAN_W'(ch);
    #1;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(cfg_ready), 32'd1);
  endtask

  task automatic wait_pulse(input int ch, input string tag);
    int n;
    n = 0;
    while (!clken[ch] && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(clken[ch]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NUM_OUT-1:0] pre;
    logic seen_run;
    logic [NUM_OUT-1:0] exp;

    rst = 1'b1; pll_locked = 1'b0; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_en = 1'b0; cfg_div = '0; cfg_phase = '0; resync = 1'b0;
    repeat (3) tick();
    check("rst_clken", 32'(clken), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Configs written while waiting for lock apply on the next cycle
    cfg_write(0, 1'b1, 4, 1);
    check("wl_pending", 32'(cfg_ready), 32'd0);
    tick();
    check("wl_applied", 32'(cfg_ready), 32'd1);
    cfg_write(1, 1'b1, 0, 5);
    tick();

    // Lock qualification with a one-cycle dropout at count 10
    pre = '0; seen_run = 1'b0;
    pll_locked = 1'b1;
    repeat (10) begin tick(); pre |= clken; seen_run |= running; end
    pll_locked = 1'b0;
    tick(); pre |= clken; seen_run |= running;
    pll_locked = 1'b1;
    n = 0;
    while (!running && n < 60) begin
      tick();
      n++;
      if (!running) pre |= clken;
    end
    check("lock_delay", 32'(n), 32'(LOCK_STABLE + 2));
    check("no_early_run", 32'(seen_run), 32'd0);
    check("no_early_clken", 32'(pre), 32'd0);

    // Divide/phase: ch0 div4 ph1 -> pulses at +2,+6,+10; ch1 div0 -> every cycle
    check("div_ph_0", 32'(clken), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp = '0;
      exp[0] = (j >= 2) && (((j - 2) % 4) == 0);
      exp[1] = 1'b1;
      check($sformatf("div_ph_%0d", j), 32'(clken), 32'(exp));
    end

    // Glitch-free update: move ch0 to div10 ph9, then write div3 ph2 mid-period
    cfg_write(0, 1'b1, 10, 9);
    check("upd_pending", 32'(cfg_ready), 32'd0);
    wait_ready(0, "upd_apply");
    wait_pulse(0, "upd_first_pulse");
    repeat (3) tick();
    cfg_write(0, 1'b1, 3, 2);
    cfg_valid = 1'b1; cfg_div = DIV_W'(5); cfg_phase = '0;
    for (int k = 4; k <= 9; k++) begin
      check($sformatf("upd_old_clken_%0d", k), 32'(clken[0]), 32'd0);
      check($sformatf("upd_stall_ready_%0d", k), 32'(cfg_ready), 32'd0);
      tick();
    end
    check("upd_ready_wrap", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    check("upd_old_last_pulse", 32'(clken[0]), 32'd1);
    for (int k = 11; k <= 19; k++) begin
      tick();
      check($sformatf("upd_new_%0d", k), 32'(clken[0]), 32'((k == 13) || (k == 16) || (k == 19)));
    end

    // Resync setup: ch2 long period, ch0 div6, ch1 div4, then a pending ch2 update
    cfg_write(2, 1'b1, 50, 0);
    wait_ready(2, "rs_ch2_init");
    cfg_write(0, 1'b1, 6, 0);
    wait_ready(0, "rs_ch0_init");
    cfg_write(1, 1'b1, 4, 0);
    wait_ready(1, "rs_ch1_init");
    cfg_write(2, 1'b1, 2, 0);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    cfg_chan = CHAN_W'(2);
    #1;
`ifdef CAPTURE_CLKEN_RESYNC_EN
    check("rs_ch2_applied", 32'(cfg_ready), 32'd1);
    for (int k = 2; k <= 13; k++) begin
      tick();
      exp = '0;
      exp[0] = ((k - 2) % 6) == 0;
      exp[1] = ((k - 2) % 4) == 0;
      exp[2] = ((k - 2) % 2) == 0;
      check($sformatf("rs_align_%0d", k), 32'(clken), 32'(exp));
    end
`else
    check("rs_ignored_pending", 32'(cfg_ready), 32'd0);
    wait_ready(2, "rs_ch2_late_apply");
`endif

    // Out-of-range channel: accepted and dropped
    cfg_chan = CHAN_W'(3);
    #1;
    check("oor_ready_before", 32'(cfg_ready), 32'd1);
    cfg_write(3, 1'b0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      cfg_chan = CHAN_W'(c);
      #1;
      check($sformatf("oor_no_pending_ch%0d", c), 32'(cfg_ready), 32'd1);
    end

    // Lock loss: ch1 pulses every cycle, clken/running fall 3 cycles after the pin
    cfg_write(1, 1'b1, 1, 0);
    wait_ready(1, "ll_ch1_apply");
    tick();
    tick();
    check("ll_base_clken", 32'(clken[1]), 32'd1);
    pll_locked = 1'b0;
    tick();
    check("ll_c1_running", 32'(running), 32'd1);
    check("ll_c1_clken", 32'(clken[1]), 32'd1);
    tick();
    check("ll_c2_running", 32'(running), 32'd1);
    check("ll_c2_clken", 32'(clken[1]), 32'd1);
    tick();
    check("ll_c3_running", 32'(running), 32'd0);
    check("ll_c3_clken", 32'(clken), 32'd0);
    check("ll_c3_lock_lost", 32'(lock_lost), 32'd1);
    tick();
    check("ll_c4_clken", 32'(clken), 32'd0);
    pll_locked = 1'b1;
    n = 0;
    while (!running && n < 60) begin
      tick();
      n++;
    end
    check("ll_relock_delay", 32'(n), 32'(LOCK_STABLE + 2));
    check("ll_sticky", 32'(lock_lost), 32'd1);

    // Reset mid-operation with a pending config
    cfg_write(0, 1'b1, 5, 0);
    rst = 1'b1;
    tick();
    cfg_chan = '0;
    #1;
    check("rst2_running", 32'(running), 32'd0);
    check("rst2_lock_lost", 32'(lock_lost), 32'd0);
    check("rst2_clken", 32'(clken), 32'd0);
    check("rst2_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
